// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: sends a packet of 1..MAX_BYTES bytes to the
// host as 11-bit frames, generating the PS/2 clock itself (open-drain style).
//
// Ports:
//   CLK, RESET         system clock, synchronous active-high reset
//   SEND               one-cycle start request (accepted only while BUSY=0)
//   NUM_BYTES          bytes to send, clamped to MAX_BYTES; sampled on SEND
//   PACKET_DATA        packet bytes, byte 0 in [7:0]; sampled on SEND
//   FORCE_PARITY_ERR   invert the parity bit of every byte; sampled on SEND
//   PS2_CLK_IN         sensed PS/2 clock line level
//   PS2_DATA_IN        sensed PS/2 data line level
//   PS2_CLK_OE         1 = pull clock line low
//   PS2_DATA_OE        1 = pull data line low
//   BUSY               packet in progress
//   DONE               one-cycle pulse when every byte has been sent
//   ABORTED            one-cycle pulse when the host inhibits mid-byte

module ps2_device_tx #(
    parameter int CLK_DIV     = 2500,
    parameter int MAX_BYTES   = 4,
    parameter int GAP_CYCLES  = 5000,
    parameter int IDLE_CYCLES = 100
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             SEND,
    input  logic [$clog2(MAX_BYTES+1)-1:0]   NUM_BYTES,
    input  logic [8*MAX_BYTES-1:0]           PACKET_DATA,
    input  logic                             FORCE_PARITY_ERR,
    input  logic                             PS2_CLK_IN,
    input  logic                             PS2_DATA_IN,
    output logic                             PS2_CLK_OE,
    output logic                             PS2_DATA_OE,
    output logic                             BUSY,
    output logic                             DONE,
    output logic                             ABORTED
);

    localparam int NW = $clog2(MAX_BYTES + 1);

    // One shared counter serves the bit, gap and idle timers.
    localparam int CMAX =
        (CLK_DIV > GAP_CYCLES)
            ? ((CLK_DIV > IDLE_CYCLES) ? CLK_DIV : IDLE_CYCLES)
            : ((GAP_CYCLES > IDLE_CYCLES) ? GAP_CYCLES : IDLE_CYCLES);
    localparam int CW = $clog2(CMAX + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        BIT_HI,
        BIT_LO,
        GAP,
        FINISH
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [3:0]             bit_idx;
    logic [NW-1:0]          bytes_left;
    logic [8*MAX_BYTES-1:0] shreg;
    logic                   force_par;

    logic [NW-1:0]          num_clamped;
    logic                   accept;
    logic [7:0]             cur_byte;

    assign num_clamped = (NUM_BYTES > NW'(MAX_BYTES)) ? NW'(MAX_BYTES)
                                                      : NUM_BYTES;
    assign accept      = SEND & ~BUSY;
    assign cur_byte    = shreg[7:0];

    // Frame bit idx of byte b: start, 8 data LSB first, odd parity, stop.
    function automatic logic frame_bit(
        input logic [7:0] b,
        input logic [3:0] idx,
        input logic       fp
    );
        logic r;
        if (idx == 4'd0)
            r = 1'b0;
        else if (idx <= 4'd8)
            r = b[idx[2:0] - 3'd1];
        else if (idx == 4'd9)
            r = ~(^b) ^ fp;
        else
            r = 1'b1;
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            bytes_left  <= '0;
            shreg       <= '0;
            force_par   <= 1'b0;
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ABORTED     <= 1'b0;
        end else begin
            DONE    <= 1'b0;
            ABORTED <= 1'b0;
            if (accept) begin
                // BUSY is low only in IDLE and FINISH, so a new packet may
                // start from either of them.
                PS2_CLK_OE  <= 1'b0;
                PS2_DATA_OE <= 1'b0;
                cnt         <= '0;
                bit_idx     <= '0;
                shreg       <= PACKET_DATA;
                force_par   <= FORCE_PARITY_ERR;
                bytes_left  <= num_clamped;
                if (num_clamped == '0) begin
                    DONE  <= 1'b1;
                    state <= IDLE;
                end else begin
                    BUSY  <= 1'b1;
                    state <= WAIT_IDLE;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        cnt <= '0;
                    end

                    WAIT_IDLE: begin
                        if (PS2_CLK_IN && PS2_DATA_IN) begin
                            if (cnt == IDLE_LAST) begin
                                cnt         <= '0;
                                bit_idx     <= '0;
                                // Start bit is 0: pull data low.
                                PS2_DATA_OE <= 1'b1;
                                state       <= BIT_HI;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end

                    BIT_HI: begin
                        // The first cycle is skipped so that our own clock
                        // release is not mistaken for a host inhibit.
                        if (!PS2_CLK_IN && cnt != '0 &&
                            bit_idx <= 4'd9) begin
                            PS2_CLK_OE  <= 1'b0;
                            PS2_DATA_OE <= 1'b0;
                            BUSY        <= 1'b0;
                            ABORTED     <= 1'b1;
                            bytes_left  <= '0;
                            cnt         <= '0;
                            state       <= IDLE;
                        end else if (cnt == BIT_LAST) begin
                            cnt        <= '0;
                            PS2_CLK_OE <= 1'b1;
                            state      <= BIT_LO;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end

                    BIT_LO: begin
                        if (cnt == BIT_LAST) begin
                            cnt        <= '0;
                            PS2_CLK_OE <= 1'b0;
                            if (bit_idx == 4'd10) begin
                                PS2_DATA_OE <= 1'b0;
                                shreg       <= shreg >> 8;
                                bytes_left  <= bytes_left - NW'(1);
                                if (bytes_left == NW'(1)) begin
                                    DONE  <= 1'b1;
                                    BUSY  <= 1'b0;
                                    state <= FINISH;
                                end else begin
                                    state <= GAP;
                                end
                            end else begin
                                bit_idx     <= bit_idx + 4'd1;
                                PS2_DATA_OE <= ~frame_bit(cur_byte,
                                                          bit_idx + 4'd1,
                                                          force_par);
                                state       <= BIT_HI;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end

                    GAP: begin
                        if (cnt == GAP_LAST) begin
                            cnt   <= '0;
                            state <= WAIT_IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end

                    FINISH: begin
                        PS2_CLK_OE  <= 1'b0;
                        PS2_DATA_OE <= 1'b0;
                        cnt         <= '0;
                        state       <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Testbench for ps2_device_tx: decodes frames from the OE waveform and
// compares them with frames built from the byte values.

module tb_ps2_device_tx;

    localparam int CLK_DIV     = 4;
    localparam int MAX_BYTES   = 4;
    localparam int GAP_CYCLES  = 6;
    localparam int IDLE_CYCLES = 2;
    localparam int NW          = $clog2(MAX_BYTES + 1);
    localparam int FRAME_CYC   = 22 * CLK_DIV;
    localparam int PITCH       = FRAME_CYC + GAP_CYCLES + IDLE_CYCLES;
    localparam int LIMIT       = 2000;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   send = 1'b0;
    logic [NW-1:0]          num_bytes = '0;
    logic [8*MAX_BYTES-1:0] packet_data = '0;
    logic                   force_parity_err = 1'b0;
    logic                   host_clk = 1'b1;
    logic                   host_data = 1'b1;
    logic                   ps2_clk_in;
    logic                   ps2_data_in;
    logic                   clk_oe;
    logic                   data_oe;
    logic                   busy;
    logic                   done;
    logic                   aborted;

    // Wired-AND open-drain lines.
    assign ps2_clk_in  = host_clk & ~clk_oe;
    assign ps2_data_in = host_data & ~data_oe;

    ps2_device_tx #(
        .CLK_DIV    (CLK_DIV),
        .MAX_BYTES  (MAX_BYTES),
        .GAP_CYCLES (GAP_CYCLES),
        .IDLE_CYCLES(IDLE_CYCLES)
    ) dut (
        .CLK             (clk),
        .RESET           (reset),
        .SEND            (send),
        .NUM_BYTES       (num_bytes),
        .PACKET_DATA     (packet_data),
        .FORCE_PARITY_ERR(force_parity_err),
        .PS2_CLK_IN      (ps2_clk_in),
        .PS2_DATA_IN     (ps2_data_in),
        .PS2_CLK_OE      (clk_oe),
        .PS2_DATA_OE     (data_oe),
        .BUSY            (busy),
        .DONE            (done),
        .ABORTED         (aborted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: a bit is taken when the device pulls the clock low.
    bit   bits[$];
    int   starts[$];
    int   nbit = 0;
    int   done_cnt = 0;
    int   abort_cnt = 0;
    int   done_cyc = 0;
    int   oe_cycles = 0;
    int   both_cnt = 0;
    logic prev_clk_oe = 1'b0;

    always @(negedge clk) begin
        if (reset || aborted) nbit = 0;
        if (clk_oe && !prev_clk_oe) begin
            if (nbit == 0) starts.push_back(cyc - CLK_DIV);
            bits.push_back(~data_oe);
            nbit = (nbit == 10) ? 0 : nbit + 1;
        end
        prev_clk_oe = clk_oe;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (aborted) abort_cnt++;
        if (done && aborted) both_cnt++;
        if (clk_oe || data_oe) oe_cycles++;
    end

    int compared = 0;
    int mismatched = 0;
    int send_cyc = 0;

    task automatic check(string tag, int obs, int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Expected frame, bit i at position i.
    function automatic int model_frame(logic [7:0] b, bit f);
        bit par;
        par = (($countones(b) % 2) == 0) ^ f;
        return int'({1'b1, par, b, 1'b0});
    endfunction

    function automatic int obs_frame(int base, int f);
        int v = 0;
        for (int i = 0; i < 11; i++) begin
            if (base + f * 11 + i >= bits.size()) return -1;
            v |= int'(bits[base + f * 11 + i]) << i;
        end
        return v;
    endfunction

    task automatic send_pkt(int n, logic [31:0] d, bit f);
        send             = 1'b1;
        num_bytes        = NW'(n);
        packet_data      = d;
        force_parity_err = f;
        step();
        send_cyc = cyc;
        send     = 1'b0;
    endtask

    task automatic wait_end(string tag, int d0, int a0);
        int i;
        for (i = 0; i < LIMIT; i++) begin
            if (done_cnt > d0 || abort_cnt > a0) break;
            step();
        end
        check({tag, "_timeout"}, int'(i >= LIMIT), 0);
    endtask

    task automatic check_packet(string tag, int bb, int sb, int n,
                                logic [31:0] d, bit f, int d0, int a0);
        int si;
        check({tag, "_nbits"}, bits.size() - bb, 11 * n);
        for (int k = 0; k < n; k++)
            check($sformatf("%s_frame%0d", tag, k), obs_frame(bb, k),
                  model_frame(d[8*k +: 8], f));
        for (int k = 1; k < n; k++) begin
            si = sb + k;
            check($sformatf("%s_pitch%0d", tag, k),
                  (si < starts.size()) ? starts[si] - starts[si-1] : -1,
                  PITCH);
        end
        check({tag, "_done"}, done_cnt, d0 + 1);
        check({tag, "_abort"}, abort_cnt, a0);
        if (n > 0) begin
            si = sb + n - 1;
            check({tag, "_done_lat"},
                  (si < starts.size()) ? done_cyc - starts[si] : -1,
                  FRAME_CYC);
        end
    endtask

    initial begin
        int bb, sb, d0, a0, oe0, n, ne, i;
        logic [31:0] d;
        bit f;

        // Reset state
        repeat (3) step();
        check("rst_clk_oe", clk_oe, 0);
        check("rst_data_oe", data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        reset = 1'b0;
        repeat (3) step();

        // Single byte 0x08
        bb = bits.size(); sb = starts.size();
        d0 = done_cnt; a0 = abort_cnt;
        send_pkt(1, 32'h08, 1'b0);
        check("t1_busy", busy, 1);
        wait_end("t1", d0, a0);
        check("t1_idle_lat",
              (sb < starts.size()) ? starts[sb] - send_cyc : -1,
              IDLE_CYCLES);
        check_packet("t1", bb, sb, 1, 32'h08, 1'b0, d0, a0);
        repeat (5) step();

        // Three bytes, with an ignored SEND while busy
        bb = bits.size(); sb = starts.size();
        d0 = done_cnt; a0 = abort_cnt;
        send_pkt(3, 32'h00FB0509, 1'b0);
        for (i = 0; i < LIMIT && bits.size() < bb + 3; i++) step();
        send_pkt(1, 32'hFFFFFFFF, 1'b1);
        wait_end("t2", d0, a0);
        check_packet("t2", bb, sb, 3, 32'h00FB0509, 1'b0, d0, a0);
        repeat (5) step();

        // Forced parity error
        bb = bits.size(); sb = starts.size();
        d0 = done_cnt; a0 = abort_cnt;
        send_pkt(1, 32'h00, 1'b1);
        wait_end("t3", d0, a0);
        check_packet("t3", bb, sb, 1, 32'h00, 1'b1, d0, a0);
        repeat (5) step();

        // Host inhibit during BIT_HI of bit 4 (data bit 3 = 0)
        bb = bits.size();
        d0 = done_cnt; a0 = abort_cnt;
        send_pkt(3, 32'h112230, 1'b0);
        for (i = 0; i < LIMIT && bits.size() < bb + 4; i++) step();
        for (i = 0; i < LIMIT && clk_oe !== 1'b0; i++) step();
        step();
        host_clk = 1'b0;
        step();
        check("t4_clk_oe", clk_oe, 0);
        check("t4_data_oe", data_oe, 0);
        check("t4_aborted", aborted, 1);
        check("t4_busy", busy, 0);
        host_clk = 1'b1;
        repeat (400) step();
        check("t4_nbits", bits.size() - bb, 4);
        check("t4_done", done_cnt, d0);
        check("t4_abort_cnt", abort_cnt, a0 + 1);

        // NUM_BYTES = 0
        d0 = done_cnt; oe0 = oe_cycles;
        send_pkt(0, 32'hDEADBEEF, 1'b0);
        check("t5_done", done, 1);
        check("t5_busy", busy, 0);
        repeat (20) step();
        check("t5_done_cnt", done_cnt, d0 + 1);
        check("t5_oe", oe_cycles, oe0);

        // NUM_BYTES = 7 clamps to 4
        bb = bits.size(); sb = starts.size();
        d0 = done_cnt; a0 = abort_cnt;
        send_pkt(7, 32'hC3A55A3C, 1'b0);
        wait_end("t6", d0, a0);
        check_packet("t6", bb, sb, 4, 32'hC3A55A3C, 1'b0, d0, a0);
        repeat (5) step();

        // Host clock low during bit 10 is ignored
        bb = bits.size(); sb = starts.size();
        d0 = done_cnt; a0 = abort_cnt;
        send_pkt(1, 32'h81, 1'b0);
        for (i = 0; i < LIMIT && bits.size() < bb + 10; i++) step();
        for (i = 0; i < LIMIT && clk_oe !== 1'b0; i++) step();
        step();
        host_clk = 1'b0;
        repeat (3) step();
        host_clk = 1'b1;
        wait_end("t7", d0, a0);
        check_packet("t7", bb, sb, 1, 32'h81, 1'b0, d0, a0);
        repeat (5) step();

        // Reset mid byte 2, reset wins over a simultaneous SEND
        bb = bits.size();
        d0 = done_cnt; a0 = abort_cnt;
        send_pkt(3, 32'h7E3CA5, 1'b0);
        for (i = 0; i < LIMIT && bits.size() < bb + 27; i++) step();
        reset       = 1'b1;
        send        = 1'b1;
        num_bytes   = NW'(1);
        packet_data = 32'h55;
        step();
        check("t8_clk_oe", clk_oe, 0);
        check("t8_data_oe", data_oe, 0);
        check("t8_busy", busy, 0);
        check("t8_done", done, 0);
        check("t8_aborted", aborted, 0);
        reset = 1'b0;
        send  = 1'b0;
        oe0   = oe_cycles;
        repeat (300) step();
        check("t8_quiet_oe", oe_cycles, oe0);
        check("t8_done_cnt", done_cnt, d0);
        check("t8_abort_cnt", abort_cnt, a0);
        bb = bits.size(); sb = starts.size();
        send_pkt(1, 32'h5A, 1'b0);
        wait_end("t8b", d0, a0);
        check_packet("t8b", bb, sb, 1, 32'h5A, 1'b0, d0, a0);
        repeat (5) step();

        // Randomized packets
        for (int r = 0; r < 8; r++) begin
            n  = int'($urandom_range(0, 7));
            d  = $urandom;
            f  = bit'($urandom_range(0, 1));
            ne = (n > MAX_BYTES) ? MAX_BYTES : n;
            bb = bits.size(); sb = starts.size();
            d0 = done_cnt; a0 = abort_cnt;
            send_pkt(n, d, f);
            wait_end($sformatf("rnd%0d", r), d0, a0);
            check_packet($sformatf("rnd%0d", r), bb, sb, ne, d, f, d0, a0);
            repeat (int'($urandom_range(1, 10))) step();
        end

        check("done_and_aborted", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
